// File: rtl/arb2_stream_mux_if.sv
// Stream bundle for the two-source packet arbiter: two input streams and one
// registered output stream, with DUT-side (slave) and environment-side (master) views.
interface arb2_stream_mux_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;

  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_sel;
  logic             out_ready;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last, out_sel,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_sel,
    output out_ready
  );
endinterface

// File: rtl/arb2_stream_mux.sv
// Two-source packet arbiter: a packet that starts on one source owns the output
// until its last beat; single-beat contention alternates via a priority bit.
module arb2_stream_mux #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  arb2_stream_mux_if.slave     bus,
  output logic                 state_dbg,
  output logic                 gnt_dbg,
  output logic                 prio_dbg
);

  // Handshake: a beat moves on any interface in the cycle where valid && ready
  // are both high at the rising edge. Input readies never wait on the output
  // transfer itself, only on the slot being empty or draining this cycle.
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             gnt, gnt_nxt;
  logic             prio, prio_nxt;

  logic             slot_free;
  logic             cand;
  logic             cand_vld;
  logic             rdy0, rdy1;
  logic             xfer;
  logic             xfer_last;
  logic [WIDTH-1:0] xfer_data;

  always_comb begin
    slot_free = !bus.out_valid || bus.out_ready;
    cand      = 1'b0;
    cand_vld  = 1'b0;
    state_nxt = state;
    gnt_nxt   = gnt;
    prio_nxt  = prio;

    // In LOCK the owner is offered the slot whether or not it is valid, so its
    // ready never depends on its own valid.
    if (state == LOCK) begin
      cand     = gnt;
      cand_vld = 1'b1;
    end else if (bus.in0_valid && bus.in1_valid) begin
      cand     = prio;
      cand_vld = 1'b1;
    end else if (bus.in1_valid) begin
      cand     = 1'b1;
      cand_vld = 1'b1;
    end else if (bus.in0_valid) begin
      cand     = 1'b0;
      cand_vld = 1'b1;
    end

    rdy0 = !rst && cand_vld && !cand && slot_free;
    rdy1 = !rst && cand_vld &&  cand && slot_free;

    xfer      = cand ? (rdy1 && bus.in1_valid) : (rdy0 && bus.in0_valid);
    xfer_last = cand ? bus.in1_last : bus.in0_last;
    xfer_data = cand ? bus.in1_data : bus.in0_data;

    if (xfer) begin
      if (xfer_last) begin
        state_nxt = IDLE;
        prio_nxt  = ~cand;
      end else if (state == IDLE) begin
        state_nxt = LOCK;
        gnt_nxt   = cand;
      end
    end
  end

  assign bus.in0_ready = rdy0;
  assign bus.in1_ready = rdy1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      prio  <= prio_nxt;
    end
  end

  // Output register: payload fields only change on an accepted beat, so they
  // hold their last values once the beat has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sel   <= 1'b0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= xfer_data;
      bus.out_last  <= xfer_last;
      bus.out_sel   <= cand;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  assign state_dbg = (state == LOCK);
  assign gnt_dbg   = gnt;
  assign prio_dbg  = prio;

endmodule

// File: tb/tb_arb2_stream_mux.sv
// Bench for arb2_stream_mux: directed scenarios plus random stress, all checked
// against a packet-level reference model with an expected-beat queue.
module tb_arb2_stream_mux;
  localparam int W = 8;

  logic clk;
  logic rst;
  logic state_dbg, gnt_dbg, prio_dbg;

  arb2_stream_mux_if #(.WIDTH(W)) bus ();

  arb2_stream_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .gnt_dbg   (gnt_dbg),
    .prio_dbg  (prio_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  int             n_checks = 0;
  int             n_errors = 0;
  logic [W+1:0]   exp_q[$];        // {sel, last, data} of accepted beats
  logic [W+1:0]   hold_beat;       // last beat presented on the output
  int             m_owner;         // -1 when no packet is in progress
  logic           m_prio;

  // values sampled during the most recent step, for directed checks
  logic           s_out_valid, s_out_last, s_out_sel, s_rdy0, s_rdy1, s_lock;
  logic [W-1:0]   s_out_data;
  logic           s_acc0, s_acc1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic accept(input logic src, input logic [W-1:0] d, input logic l);
    exp_q.push_back({src, l, d});
    if (l) begin
      m_owner = -1;
      m_prio  = ~src;
    end else begin
      m_owner = int'(src);
    end
  endtask

  // One clock cycle: drive inputs, check outputs and readies against the model,
  // then advance the model across the coming rising edge.
  task automatic step(input logic v0, input logic [W-1:0] d0, input logic l0,
                      input logic v1, input logic [W-1:0] d1, input logic l1,
                      input logic ordy, input logic r);
    logic         exp_ov;
    logic [W+1:0] front;
    int           grant;
    logic         sf, e0, e1;
    @(negedge clk);
    rst           = r;
    bus.in0_valid = v0; bus.in0_data = d0; bus.in0_last = l0;
    bus.in1_valid = v1; bus.in1_data = d1; bus.in1_last = l1;
    bus.out_ready = ordy;
    #1;
    exp_ov = (exp_q.size() != 0);
    front  = exp_ov ? exp_q[0] : hold_beat;
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("out_data",  32'(bus.out_data),  32'(front[W-1:0]));
    check("out_last",  32'(bus.out_last),  32'(front[W]));
    check("out_sel",   32'(bus.out_sel),   32'(front[W+1]));
    check("lock",      32'(state_dbg),     32'(m_owner >= 0));
    check("prio",      32'(prio_dbg),      32'(m_prio));
    if (m_owner >= 0) check("gnt", 32'(gnt_dbg), 32'(m_owner));

    if (m_owner >= 0)      grant = m_owner;
    else if (v0 && v1)     grant = int'(m_prio);
    else if (v0)           grant = 0;
    else if (v1)           grant = 1;
    else                   grant = -1;
    sf = !exp_ov || ordy;
    e0 = !r && sf && (grant == 0);
    e1 = !r && sf && (grant == 1);
    check("in0_ready", 32'(bus.in0_ready), 32'(e0));
    check("in1_ready", 32'(bus.in1_ready), 32'(e1));

    s_out_valid = bus.out_valid; s_out_data = bus.out_data;
    s_out_last  = bus.out_last;  s_out_sel  = bus.out_sel;
    s_rdy0 = bus.in0_ready; s_rdy1 = bus.in1_ready; s_lock = state_dbg;
    s_acc0 = 1'b0; s_acc1 = 1'b0;

    if (r) begin
      exp_q.delete();
      m_owner   = -1;
      m_prio    = 1'b0;
      hold_beat = '0;
    end else begin
      if (exp_ov && ordy) hold_beat = exp_q.pop_front();
      if (e0 && v0) begin accept(1'b0, d0, l0); s_acc0 = 1'b1; end
      if (e1 && v1) begin accept(1'b1, d1, l1); s_acc1 = 1'b1; end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, ordy, 1'b0);
  endtask

  logic [W-1:0] nd[2];
  logic         nl[2];

  initial begin
    rst = 1'b1;
    bus.in0_valid = 1'b0; bus.in0_data = '0; bus.in0_last = 1'b0;
    bus.in1_valid = 1'b0; bus.in1_data = '0; bus.in1_last = 1'b0;
    bus.out_ready = 1'b0;
    m_owner = -1; m_prio = 1'b0; hold_beat = '0;

    // reset: outputs zero, readies held low
    step(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
    check("rst_rdy0", 32'(s_rdy0), 32'd0);
    check("rst_out_valid", 32'(s_out_valid), 32'd0);

    // contention of single-beat packets: source 0 first, then source 1
    step(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    check("c_rdy0", 32'(s_rdy0), 32'd1);
    check("c_rdy1", 32'(s_rdy1), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    check("c_out0", 32'({s_out_sel, s_out_data}), 32'h011);
    idle(1'b1);
    check("c_out1", 32'({s_out_sel, s_out_data}), 32'h122);

    // 3-beat packet on source 0 holds source 1 off
    step(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    check("p_rdy1_a1", 32'(s_rdy1), 32'd0);
    step(1'b1, 8'hA2, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    check("p_rdy1_a2", 32'(s_rdy1), 32'd0);
    step(1'b1, 8'hA3, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    check("p_rdy1_a3", 32'(s_rdy1), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    check("p_rdy1_b1", 32'(s_rdy1), 32'd1);
    check("p_out_a3", 32'({s_out_last, s_out_data}), 32'h1A3);
    idle(1'b1);
    check("p_out_b1", 32'({s_out_sel, s_out_data}), 32'h1B1);

    // backpressure: 0x5A held four cycles, then released
    step(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      check("bp_data", 32'(s_out_data), 32'h5A);
      check("bp_rdy",  32'({s_rdy0, s_rdy1}), 32'd0);
    end
    step(1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check("bp_release", 32'(s_rdy1), 32'd1);
    step(1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("bp_out77", 32'({s_out_sel, s_out_data}), 32'h177);
    idle(1'b1);
    idle(1'b1);
    check("drain_valid", 32'(s_out_valid), 32'd0);
    check("drain_hold",  32'(s_out_data), 32'h66);

    // source 1 owns the lock and stalls mid-packet
    step(1'b1, 8'h30, 1'b1, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b0);
    check("st_acc1", 32'(s_acc1), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h30, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("st_rdy0", 32'(s_rdy0), 32'd0);
      check("st_rdy1", 32'(s_rdy1), 32'd1);
    end
    step(1'b1, 8'h30, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b1, 1'b0);
    check("st_rdy0_last", 32'(s_rdy0), 32'd0);
    step(1'b1, 8'h30, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("st_rdy0_after", 32'(s_rdy0), 32'd1);
    idle(1'b1);

    // reset during the second beat of a source 1 packet
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hD2, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    check("mr_out", 32'({s_out_valid, s_out_last, s_out_sel, s_out_data}), 32'd0);
    check("mr_lock", 32'(s_lock), 32'd0);
    check("mr_grant", 32'({s_rdy0, s_rdy1}), 32'b10);
    idle(1'b1);
    idle(1'b1);

    // random stress
    for (int s = 0; s < 2; s++) begin
      nd[s] = W'($urandom);
      nl[s] = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(0, 9) < 7), nd[0], nl[0],
           ($urandom_range(0, 9) < 7), nd[1], nl[1],
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
      if (s_acc0) begin nd[0] = W'($urandom); nl[0] = ($urandom_range(0, 3) == 0); end
      if (s_acc1) begin nd[1] = W'($urandom); nl[1] = ($urandom_range(0, 3) == 0); end
    end
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
